// File: rtl/imem_boot_pkg.sv
// rtl/imem_boot_pkg.sv - shared state encoding and default sizing for imem_boot_ctrl
package imem_boot_pkg;

  localparam int DEF_IMEM_DEPTH  = 256;
  localparam int DEF_RELEASE_DLY = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_HOLD = 3'd2,
    S_RUN  = 3'd3,
    S_ERR  = 3'd4
  } boot_state_t;

endpackage

// File: rtl/imem_boot_ctrl.sv
// rtl/imem_boot_ctrl.sv - streams boot words into imem, then releases the core from reset
// Optional feature macro IMEM_BOOT_CKSUM_EN: a trailing checksum beat is verified before release.
module imem_boot_ctrl
  import imem_boot_pkg::*;
#(
  parameter int IMEM_DEPTH  = DEF_IMEM_DEPTH,
  parameter int RELEASE_DLY = DEF_RELEASE_DLY
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [31:0]                   ld_data,
  input  logic                          ld_last,
  output logic                          imem_we,
  output logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  output logic [31:0]                   imem_wdata,
  output logic                          core_resetn,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [$clog2(IMEM_DEPTH):0]   word_cnt
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int CW = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY) : 1;
  localparam logic [AW:0]   LP_DEPTH     = (AW+1)'(IMEM_DEPTH);
  localparam logic [AW:0]   LP_TOP       = (AW+1)'(IMEM_DEPTH - 1);
  localparam logic [CW-1:0] LP_HOLD_LAST = CW'(RELEASE_DLY - 1);

  boot_state_t   r_state;
  boot_state_t   w_next;
  logic [CW-1:0] r_hold_cnt;
  logic          w_accept;
  logic          w_data_beat;
  logic          w_at_top;
  logic          w_enter_load;

  assign ld_ready     = (r_state == S_LOAD);
  assign core_resetn  = (r_state == S_RUN);
  assign done         = (r_state == S_RUN);
  assign busy         = (r_state == S_LOAD) || (r_state == S_HOLD);
  assign err          = (r_state == S_ERR);

  assign w_accept     = ld_valid && ld_ready;
  assign w_at_top     = (word_cnt == LP_TOP);
  assign w_enter_load = (w_next == S_LOAD) && (r_state != S_LOAD);

`ifdef IMEM_BOOT_CKSUM_EN
  // r_ck_phase: the ld_last word has been taken, the next beat carries the sum
  logic        r_ck_phase;
  logic [31:0] r_sum;

  assign w_data_beat = w_accept && !r_ck_phase;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ck_phase <= 1'b0;
      r_sum      <= 32'd0;
    end else if (w_enter_load) begin
      r_ck_phase <= 1'b0;
      r_sum      <= 32'd0;
    end else if (w_data_beat) begin
      r_sum <= r_sum + ld_data;
      if (ld_last) r_ck_phase <= 1'b1;
    end
  end
`else
  assign w_data_beat = w_accept;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_LOAD;
      S_LOAD: begin
        if (w_accept) begin
`ifdef IMEM_BOOT_CKSUM_EN
          if (r_ck_phase)             w_next = (ld_data == r_sum) ? S_HOLD : S_ERR;
          else if (!ld_last && w_at_top) w_next = S_ERR;
`else
          if (ld_last)       w_next = S_HOLD;
          else if (w_at_top) w_next = S_ERR;
`endif
        end
      end
      S_HOLD: if (r_hold_cnt == LP_HOLD_LAST) w_next = S_RUN;
      S_RUN, S_ERR: if (start) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= 32'd0;
      word_cnt   <= '0;
      r_hold_cnt <= '0;
    end else begin
      imem_we <= w_data_beat;
      if (w_data_beat) begin
        imem_waddr <= word_cnt[AW-1:0];
        imem_wdata <= ld_data;
      end
      if (w_enter_load)                           word_cnt <= '0;
      else if (w_data_beat && word_cnt != LP_DEPTH) word_cnt <= word_cnt + 1'b1;
      // counts the cycles spent in HOLD; restarts on every HOLD entry
      if (r_state == S_HOLD) r_hold_cnt <= r_hold_cnt + 1'b1;
      else                   r_hold_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb/tb_imem_boot_ctrl.sv - scoreboard bench for imem_boot_ctrl with a tiny RV32 core model
module tb_imem_boot_ctrl;

  localparam int DEPTH = 32;
  localparam int DLY   = 4;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          ld_valid = 1'b0;
  logic          ld_last = 1'b0;
  logic [31:0]   ld_data = 32'd0;
  logic          ld_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          core_resetn;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   word_cnt;

  imem_boot_ctrl #(.IMEM_DEPTH(DEPTH), .RELEASE_DLY(DLY)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .core_resetn(core_resetn), .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          m_idx = 0;
  logic [31:0] core_mem [DEPTH];

  always @(posedge clk) if (imem_we) core_mem[imem_waddr] <= imem_wdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (imem_we === 1'b1) begin
        if (exp_q.size() == 0) check("spurious_we", imem_we, 0);
        else begin
          e = exp_q.pop_front();
          check("wr_addr", imem_waddr, e.addr);
          check("wr_data", imem_wdata, e.data);
        end
      end
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input bit last, input bit is_data, output bit acc);
    @(negedge clk);
    ld_valid = 1'b1; ld_data = d; ld_last = last; acc = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ld_ready) begin
        if (is_data && m_idx < DEPTH) begin
          exp_q.push_back('{m_idx, d});
          m_idx++;
        end
        @(posedge clk);
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1;
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    m_idx = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_session(input logic [31:0] w[$], input int gmin, input int gmax,
                              input int stray_at, input bit cks_good);
    logic [31:0] sum;
    bit          acc;
    sum = 32'd0;
    for (int i = 0; i < w.size(); i++) begin
      if (i > 0) repeat ($urandom_range(gmax, gmin)) @(negedge clk);
      if (i == stray_at) begin
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
      end
      sum = sum + w[i];
      send_beat(w[i], i == w.size() - 1, 1'b1, acc);
      check("beat_acc", acc, 1);
    end
`ifdef IMEM_BOOT_CKSUM_EN
    send_beat(cks_good ? sum : sum + 32'd1, 1'b0, 1'b0, acc);
    check("cks_acc", acc, 1);
`else
    if (cks_good) sum = 32'd0;
`endif
  endtask

  // Cycles from the write cycle of the final beat until core_resetn is seen high.
  task automatic wait_release(input bit hold_start, output int cyc);
    @(negedge clk);
    if (hold_start) start = 1'b1;
    cyc = 0;
    while (!core_resetn && cyc < 60) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
  endtask

  task automatic run_core(input int n, output int r1, output int r2);
    int          x[32];
    logic [31:0] w;
    for (int i = 0; i < 32; i++) x[i] = 0;
    for (int pc = 0; pc < n; pc++) begin
      w = core_mem[pc];
      case (w[6:0])
        7'h13: if (w[14:12] == 3'd0) x[w[11:7]] = x[w[19:15]] + int'($signed(w[31:20]));
        7'h33: x[w[11:7]] = w[30] ? x[w[19:15]] - x[w[24:20]] : x[w[19:15]] + x[w[24:20]];
        default: ;
      endcase
      x[0] = 0;
    end
    r1 = x[1];
    r2 = x[2];
  endtask

  initial begin
    logic [31:0] prog[$];
    logic [31:0] ws[$];
    int          cyc, x1, x2, n;
    bit          acc, all_acc;

    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check("rst_outs", {ld_ready, imem_we, imem_waddr, imem_wdata, core_resetn, busy, done, err, word_cnt}, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_flags", {busy, done, err, ld_ready, core_resetn}, 0);

    prog = '{32'h01908093, 32'h04b10113, 32'h002080b3, 32'h40208133, 32'h402080b3, 32'hffd08093};
    do_start();
    check("load_busy", {busy, ld_ready, core_resetn}, 3'b110);
    check("load_cnt0", word_cnt, 0);
    load_session(prog, 0, 0, -1, 1'b1);
    wait_release(1'b0, cyc);
    check("release_dly", cyc, DLY);
    check("boot_cnt", word_cnt, 6);
    check("run_flags", {done, busy, err, core_resetn}, 4'b1001);
    check("sb_drain", exp_q.size(), 0);
    run_core(6, x1, x2);
    check("core_x1", x1, 72);
    check("core_x2", x2, 25);

    // restart from RUN, spaced beats, stray start inside LOAD and inside HOLD
    do_start();
    check("restart_state", {core_resetn, busy, word_cnt}, {2'b01, (AW+1)'(0)});
    ws = '{$urandom, $urandom, $urandom, $urandom};
    load_session(ws, 3, 3, 2, 1'b1);
    wait_release(1'b1, cyc);
    check("gap_release", cyc, DLY);
    check("gap_cnt", word_cnt, 4);
    check("sb_drain", exp_q.size(), 0);

    for (int s = 0; s < 6; s++) begin
      n = $urandom_range(8, 1);
      ws.delete();
      for (int i = 0; i < n; i++) ws.push_back($urandom);
      do_start();
      check("rnd_restart", {core_resetn, done, word_cnt}, 0);
      load_session(ws, 0, 2, $urandom_range(1, 0) ? int'($urandom_range(n - 1, 0)) : -1, 1'b1);
      wait_release(1'($urandom_range(1, 0)), cyc);
      check("rnd_release", cyc, DLY);
      check("rnd_cnt", word_cnt, n);
      check("rnd_done", {done, err}, 2'b10);
    end
    check("sb_drain", exp_q.size(), 0);

    // overflow: DEPTH words with no ld_last, one more is refused
    do_start();
    all_acc = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      send_beat($urandom, 1'b0, 1'b1, acc);
      all_acc = all_acc & acc;
    end
    check("ovf_all_acc", all_acc, 1);
    send_beat($urandom, 1'b0, 1'b1, acc);
    check("ovf_extra_acc", acc, 0);
    check("ovf_flags", {err, ld_ready, core_resetn, busy, done}, 5'b10000);
    check("ovf_cnt", word_cnt, DEPTH);
    check("sb_drain", exp_q.size(), 0);

    // ERR -> LOAD, then async reset in the middle of the session
    do_start();
    check("err_restart", {busy, err, word_cnt}, {2'b10, (AW+1)'(0)});
    for (int i = 0; i < 3; i++) send_beat($urandom, 1'b0, 1'b1, acc);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1 check("async_rst", {ld_ready, imem_we, imem_waddr, imem_wdata, core_resetn, busy, done, err, word_cnt}, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_idle", {busy, done, err, ld_ready}, 0);
    do_start();
    ws = '{$urandom, $urandom};
    load_session(ws, 0, 1, -1, 1'b1);
    wait_release(1'b0, cyc);
    check("post_rst_release", cyc, DLY);
    check("post_rst_cnt", word_cnt, 2);
    check("sb_drain", exp_q.size(), 0);

`ifdef IMEM_BOOT_CKSUM_EN
    do_start();
    ws = '{32'h1, 32'h2};
    load_session(ws, 0, 0, -1, 1'b1);
    wait_release(1'b0, cyc);
    check("cks_good_done", {done, err}, 2'b10);
    do_start();
    load_session(ws, 0, 0, -1, 1'b0);
    @(negedge clk);
    check("cks_bad_err", {err, done, core_resetn}, 3'b100);
    check("sb_drain", exp_q.size(), 0);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
